// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream loader that fills the instruction RAM (optional checksum: PROGRAM_LOADER_CHECKSUM_EN)
module program_loader #(
  parameter int          ADDR_WIDTH = 16,
  parameter int          DATA_WIDTH = 28,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [7:0]            iByte,
  input  logic                  iByteValid,
  output logic                  oByteReady,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [DATA_WIDTH-1:0] oWriteData,
  output logic                  oCpuHold,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oError
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_B3,
    S_B2,
    S_B1,
    S_B0,
    S_WRITE,
    S_FINISH,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  state_t                state, state_next;
  logic                  byte_ready;
  logic                  xfer;
  logic                  start;
  logic [7:0]            len_hi;
  logic [ADDR_WIDTH-1:0] len;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] count_inc;
  logic [ADDR_WIDTH-1:0] addr;
  logic [19:0]           shift;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]            csum;
  logic                  err;
`endif

  assign xfer      = iByteValid & byte_ready;
  assign start     = iStart & ((state == S_IDLE) | (state == S_DONE));
  assign count_inc = count + 1'b1;

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; byte acceptance is a pure function of the state
  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    case (state)
      S_IDLE: begin
        if (iStart) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        if (iByteValid) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        if (iByteValid) begin
          if ({len_hi, iByte} == 16'h0000) state_next = S_FINISH;
          else                             state_next = S_B3;
        end
      end
      S_B3: begin
        byte_ready = 1'b1;
        if (iByteValid) state_next = S_B2;
      end
      S_B2: begin
        byte_ready = 1'b1;
        if (iByteValid) state_next = S_B1;
      end
      S_B1: begin
        byte_ready = 1'b1;
        if (iByteValid) state_next = S_B0;
      end
      S_B0: begin
        byte_ready = 1'b1;
        if (iByteValid) state_next = S_WRITE;
      end
      S_WRITE: begin
        if (count_inc == len) state_next = S_FINISH;
        else                  state_next = S_B3;
      end
      S_FINISH: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        state_next = S_CHK;
`else
        state_next = S_DONE;
`endif
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHK: begin
        byte_ready = 1'b1;
        if (iByteValid) state_next = S_DONE;
      end
`endif
      S_DONE: begin
        if (iStart) state_next = S_LEN_HI;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: length capture, word assembly, address/count stepping
  always_ff @(posedge Clock) begin
    if (Reset) begin
      len_hi <= 8'h00;
      len    <= '0;
      count  <= '0;
      addr   <= ADDR_WIDTH'(BASE_ADDR);
      shift  <= 20'h0;
      waddr  <= '0;
      wdata  <= '0;
    end else begin
      if (start) begin
        addr  <= ADDR_WIDTH'(BASE_ADDR);
        count <= '0;
      end
      if (xfer) begin
        case (state)
          S_LEN_HI: len_hi <= iByte;
          S_LEN_LO: len    <= ADDR_WIDTH'({len_hi, iByte});
          // Only the low nibble of the first byte carries instruction bits
          S_B3:     shift  <= {16'h0000, iByte[3:0]};
          S_B2:     shift  <= {shift[11:0], iByte};
          S_B1:     shift  <= {shift[11:0], iByte};
          S_B0: begin
            wdata <= DATA_WIDTH'({shift, iByte});
            waddr <= addr;
          end
          default: ;
        endcase
      end
      if (state == S_WRITE) begin
        addr  <= addr + 1'b1;
        count <= count_inc;
      end
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  // Running XOR over length and instruction bytes; compared against the trailing byte
  always_ff @(posedge Clock) begin
    if (Reset) begin
      csum <= 8'h00;
      err  <= 1'b0;
    end else if (start) begin
      csum <= 8'h00;
      err  <= 1'b0;
    end else if (xfer) begin
      if (state == S_CHK) err  <= (iByte != csum);
      else                csum <= csum ^ iByte;
    end
  end

  assign oError = err;
`else
  assign oError = 1'b0;
`endif

  assign oByteReady    = byte_ready;
  assign oWriteEnable  = (state == S_WRITE);
  assign oWriteAddress = waddr;
  assign oWriteData    = wdata;
  assign oBusy         = (state != S_IDLE) && (state != S_DONE);
  assign oCpuHold      = oBusy;
  assign oDone         = (state == S_DONE);

endmodule
